apb_bridge_gen: RTL and testbench
=================================

Name: apb_bridge_gen

Overview:
Parametrised next-generation AHB-side-to-APB bridge. Converts a simple master request (Hen/Hwrite/Haddr/Hwdata) into APB SETUP/ACCESS phases for NUM_SLV slaves, with wait states (Pready), slave error (Pslverr) and a decode-miss error response. Sits between the CPU bus master and the peripheral APB segment. Adds per-slave read-data/ready muxing and a registered read-data return.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width.
NUM_SLV, 4, number of APB slaves (1..16).
SLV_SEL_LSB, 8, lowest address bit of the slave-select field; each slave owns a 2^SLV_SEL_LSB-byte region.
TIMEOUT_CYC, 16, ACCESS wait-state limit. Used only with APB_BRIDGE_TIMEOUT_EN.

Ports:
PCLK  in  1  clock
Prst  in  1  asynchronous active-low reset
Hen  in  1  transfer request; held high until Hready=1 is seen
Hwrite  in  1  1=write, 0=read
Haddr  in  ADDR_W  transfer address
Hwdata  in  DATA_W  write data
Hready  out  1  one-cycle transfer-done pulse
Hresp  out  1  error flag, valid while Hready=1
Hrdata  out  DATA_W  read data, registered
Psel  out  NUM_SLV  one-hot slave select
Pen  out  1  APB enable
Pwrite  out  1  APB direction
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Prdata_m  in  NUM_SLV*DATA_W  per-slave read data; slave i at bits [i*DATA_W +: DATA_W]
Pready_m  in  NUM_SLV  per-slave ready
Pslverr_m  in  NUM_SLV  per-slave error

Behaviour:
- Reset is Prst: asynchronous, active-low. Clock is PCLK. In reset: state IDLE; Hready=0, Hresp=0, Hrdata=0, Psel=0, Pen=0, Pwrite=0, Paddr=0, Pwdata=0. Asserting reset mid-transfer aborts it immediately. No response is generated.
- Decode is combinational. sel = Haddr[ADDR_W-1:SLV_SEL_LSB]. Hit when sel < NUM_SLV; the target is slave index sel.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE with Hen=1 and a hit: latch Paddr<=Haddr, Pwrite<=Hwrite, Pwdata<=Hwdata and Psel[sel]<=1, then go to SETUP. Pen stays 0.
- IDLE with Hen=1 and a miss: no APB activity. Go to RESP with Hresp=1 and Hrdata=0.
- SETUP: Pen<=1, then go to ACCESS. This lasts exactly one cycle.
- ACCESS: hold all P* outputs stable. At the edge where Pready_m[idx]=1:
  - Psel<=0, Pen<=0.
  - Hresp<=Pslverr_m[idx].
  - Hrdata<=Prdata_m[idx] for a read without error; otherwise 0.
  - Go to RESP.
- Pready_m[idx]=0 in ACCESS inserts a wait state. Pslverr_m and Prdata_m are ignored unless Pready_m[idx]=1.
- RESP: Hready=1 for exactly one cycle, then go to IDLE. Hen is not sampled in RESP, so a held Hen cannot relaunch. Hresp and Hready both return to 0 on leaving RESP.
- Hrdata holds its value until the next RESP entry.
- Paddr, Pwrite and Pwdata hold their last values between transfers.
- Minimum latency, from the Hen edge to Hready high: 3 cycles for a hit with zero waits; 1 cycle for a miss.
- Hen, Haddr, Hwrite and Hwdata are sampled only in IDLE. Changes in other states have no effect.

Optional Feature:
APB_BRIDGE_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on ACCESS entry and increments each ACCESS cycle with Pready_m[idx]=0. When it reaches TIMEOUT_CYC-1 with Pready still low, the bridge aborts: Psel/Pen<=0, Hresp<=1, Hrdata<=0, go to RESP.
- Undefined: no counter exists; ACCESS waits indefinitely.

Decomposition:
- Package apb_bridge_pkg holds:
  - the state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3);
  - the derived constant SEL_W=$clog2(NUM_SLV) (minimum 1);
  - the error-response data constant (all zeros).
- Sub-module apb_slv_decode is combinational. It takes Haddr and outputs hit, the one-hot select and the index. It is instantiated once.
- The FSM, read mux and timeout counter live in apb_bridge_gen.

Test Plan:
- Write to slave 2 with zero waits: Haddr=0x0000_0204, Hwdata=0xDEAD_BEEF.
  -> Psel=4'b0100 with Pen=0 for 1 cycle, then Pen=1 for 1 cycle, Pwdata=0xDEAD_BEEF.
  -> Hready=1, Hresp=0 on the 3rd cycle after launch.
- Read from slave 1 with 3 wait states: Haddr=0x104, Prdata_m slice1=0x1234_5678, Pready_m[1] low for 3 cycles.
  -> Pen high for 4 cycles; Hready 6 cycles after launch; Hrdata=0x1234_5678.
- Decode miss: Haddr=0x0000_0500.
  -> Psel stays 0 and Pen stays 0.
  -> Hready=1, Hresp=1, Hrdata=0 on the next cycle.
- Slave error: read slave 3 with Pslverr_m[3]=1 and Pready_m[3]=1.
  -> Hresp=1, Hrdata=0.
  -> Back-to-back: holding Hen high through RESP does not relaunch; the next transfer starts in IDLE.
- Reset mid-ACCESS: drop Prst with Pen=1.
  -> All outputs go to 0 asynchronously, there is no Hready pulse, and the FSM is in IDLE after release.
- With APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=16: Pready held at 0.
  -> Abort after 16 ACCESS cycles with Hresp=1.
  -> Without the macro, the FSM is still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared types and constants for the APB bridge.
//   apb_state_e : bridge FSM state encoding
//   calc_sel_w  : slave-index width for a given slave count (minimum 1)
//   SEL_W       : index width for the default 4-slave configuration
//   ERR_RDATA   : read data returned on any error response
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int unsigned NUM_SLV_DEF = 4;

    function automatic int unsigned calc_sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SEL_W = calc_sel_w(NUM_SLV_DEF);

    // Zero-extended/truncated to the data width at the point of use.
    localparam logic [63:0] ERR_RDATA = 64'h0;

endpackage

// File: rtl/apb_slv_decode.sv
// apb_slv_decode: combinational slave decode of the address select field.
//   i_sel_field : Haddr[ADDR_W-1:SLV_SEL_LSB]
//   o_hit_c     : field addresses an existing slave
//   o_onehot_c  : one-hot select of the addressed slave (zero on a miss)
//   o_idx_c     : binary index of the addressed slave
module apb_slv_decode
    import apb_bridge_pkg::*;
#(
    parameter int unsigned FIELD_W = 24,
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned IDX_W   = calc_sel_w(NUM_SLV)
) (
    input  logic [FIELD_W-1:0] i_sel_field,
    output logic               o_hit_c,
    output logic [NUM_SLV-1:0] o_onehot_c,
    output logic [IDX_W-1:0]   o_idx_c
);

    // Every field bit takes part in the compare so high-address aliases miss.
    always_comb begin
        o_hit_c    = (i_sel_field < FIELD_W'(NUM_SLV));
        o_idx_c    = i_sel_field[IDX_W-1:0];
        o_onehot_c = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            o_onehot_c[i] = o_hit_c && (o_idx_c == IDX_W'(i));
        end
    end

endmodule

// File: rtl/apb_bridge_gen.sv
// apb_bridge_gen: simple-master to APB bridge for NUM_SLV slaves.
//   PCLK, Prst (async, active-low)
//   Hen/Hwrite/Haddr/Hwdata : master request, sampled only in IDLE
//   Hready/Hresp/Hrdata     : one-cycle done pulse, error flag, registered read data
//   Psel/Pen/Pwrite/Paddr/Pwdata : APB master outputs
//   Prdata_m/Pready_m/Pslverr_m  : per-slave APB return signals
// Optional build macro APB_BRIDGE_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYC
// wait cycles; without it ACCESS waits indefinitely.
module apb_bridge_gen
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_SLV     = 4,
    parameter int unsigned SLV_SEL_LSB = 8,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                      PCLK,
    input  logic                      Prst,
    input  logic                      Hen,
    input  logic                      Hwrite,
    input  logic [ADDR_W-1:0]         Haddr,
    input  logic [DATA_W-1:0]         Hwdata,
    output logic                      Hready,
    output logic                      Hresp,
    output logic [DATA_W-1:0]         Hrdata,
    output logic [NUM_SLV-1:0]        Psel,
    output logic                      Pen,
    output logic                      Pwrite,
    output logic [ADDR_W-1:0]         Paddr,
    output logic [DATA_W-1:0]         Pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] Prdata_m,
    input  logic [NUM_SLV-1:0]        Pready_m,
    input  logic [NUM_SLV-1:0]        Pslverr_m
);

    localparam int unsigned SLV_IDX_W = calc_sel_w(NUM_SLV);
    localparam int unsigned FIELD_W   = ADDR_W - SLV_SEL_LSB;
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_RDATA);

    // Configuration guard: this block only elaborates for an illegal setup,
    // making a bad parameter set visible in the elaborated hierarchy.
    if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1) begin : g_illegal_cfg
    end

    apb_state_e r_state, w_state_nxt;

    logic [SLV_IDX_W-1:0] r_idx, w_idx_nxt;
    logic                 r_hready, w_hready_nxt;
    logic                 r_hresp, w_hresp_nxt;
    logic [DATA_W-1:0]    r_hrdata, w_hrdata_nxt;
    logic [NUM_SLV-1:0]   r_psel, w_psel_nxt;
    logic                 r_pen, w_pen_nxt;
    logic                 r_pwrite, w_pwrite_nxt;
    logic [ADDR_W-1:0]    r_paddr, w_paddr_nxt;
    logic [DATA_W-1:0]    r_pwdata, w_pwdata_nxt;

    logic                 w_hit;
    logic [NUM_SLV-1:0]   w_onehot;
    logic [SLV_IDX_W-1:0] w_idx;

    logic                 w_pready;
    logic                 w_pslverr;
    logic [DATA_W-1:0]    w_prdata;
    logic [DATA_W-1:0]    w_prdata_arr [NUM_SLV];

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`endif

    apb_slv_decode #(
        .FIELD_W (FIELD_W),
        .NUM_SLV (NUM_SLV),
        .IDX_W   (SLV_IDX_W)
    ) u_decode (
        .i_sel_field (Haddr[ADDR_W-1:SLV_SEL_LSB]),
        .o_hit_c     (w_hit),
        .o_onehot_c  (w_onehot),
        .o_idx_c     (w_idx)
    );

    // Per-slave return mux, steered by the index latched at launch.
    for (genvar g = 0; g < NUM_SLV; g++) begin : g_rdata_split
        assign w_prdata_arr[g] = Prdata_m[g*DATA_W +: DATA_W];
    end

    assign w_pready  = Pready_m[r_idx];
    assign w_pslverr = Pslverr_m[r_idx];
    assign w_prdata  = w_prdata_arr[r_idx];

    // State and output registers.
    always_ff @(posedge PCLK or negedge Prst) begin
        if (!Prst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_hready <= 1'b0;
            r_hresp  <= 1'b0;
            r_hrdata <= '0;
            r_psel   <= '0;
            r_pen    <= 1'b0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
            r_cnt    <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_hready <= w_hready_nxt;
            r_hresp  <= w_hresp_nxt;
            r_hrdata <= w_hrdata_nxt;
            r_psel   <= w_psel_nxt;
            r_pen    <= w_pen_nxt;
            r_pwrite <= w_pwrite_nxt;
            r_paddr  <= w_paddr_nxt;
            r_pwdata <= w_pwdata_nxt;
`ifdef APB_BRIDGE_TIMEOUT_EN
            r_cnt    <= w_cnt_nxt;
`endif
        end
    end

    // Next state and next register values. Hready/Hresp are raised on the
    // edge that enters RESP so they are high exactly for the RESP cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_hready_nxt = 1'b0;
        w_hresp_nxt  = 1'b0;
        w_hrdata_nxt = r_hrdata;
        w_psel_nxt   = r_psel;
        w_pen_nxt    = r_pen;
        w_pwrite_nxt = r_pwrite;
        w_paddr_nxt  = r_paddr;
        w_pwdata_nxt = r_pwdata;
`ifdef APB_BRIDGE_TIMEOUT_EN
        w_cnt_nxt    = r_cnt;
`endif

        case (r_state)
            ST_IDLE: begin
                if (Hen) begin
                    if (w_hit) begin
                        w_paddr_nxt  = Haddr;
                        w_pwrite_nxt = Hwrite;
                        w_pwdata_nxt = Hwdata;
                        w_psel_nxt   = w_onehot;
                        w_idx_nxt    = w_idx;
                        w_state_nxt  = ST_SETUP;
                    end else begin
                        // Decode miss: answer directly, no APB cycle.
                        w_hready_nxt = 1'b1;
                        w_hresp_nxt  = 1'b1;
                        w_hrdata_nxt = ERR_DATA;
                        w_state_nxt  = ST_RESP;
                    end
                end
            end

            ST_SETUP: begin
                w_pen_nxt   = 1'b1;
                w_state_nxt = ST_ACCESS;
`ifdef APB_BRIDGE_TIMEOUT_EN
                w_cnt_nxt   = '0;
`endif
            end

            ST_ACCESS: begin
                if (w_pready) begin
                    w_psel_nxt   = '0;
                    w_pen_nxt    = 1'b0;
                    w_hready_nxt = 1'b1;
                    w_hresp_nxt  = w_pslverr;
                    w_hrdata_nxt = (!r_pwrite && !w_pslverr) ? w_prdata : ERR_DATA;
                    w_state_nxt  = ST_RESP;
                end
`ifdef APB_BRIDGE_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_psel_nxt   = '0;
                    w_pen_nxt    = 1'b0;
                    w_hready_nxt = 1'b1;
                    w_hresp_nxt  = 1'b1;
                    w_hrdata_nxt = ERR_DATA;
                    w_state_nxt  = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end

            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign Hready = r_hready;
    assign Hresp  = r_hresp;
    assign Hrdata = r_hrdata;
    assign Psel   = r_psel;
    assign Pen    = r_pen;
    assign Pwrite = r_pwrite;
    assign Paddr  = r_paddr;
    assign Pwdata = r_pwdata;

endmodule

// File: tb/tb_apb_bridge_gen.sv
// tb_apb_bridge_gen: self-checking bench for apb_bridge_gen (default parameters).
module tb_apb_bridge_gen;

    logic         PCLK;
    logic         Prst;
    logic         Hen;
    logic         Hwrite;
    logic [31:0]  Haddr;
    logic [31:0]  Hwdata;
    logic         Hready;
    logic         Hresp;
    logic [31:0]  Hrdata;
    logic [3:0]   Psel;
    logic         Pen;
    logic         Pwrite;
    logic [31:0]  Paddr;
    logic [31:0]  Pwdata;
    logic [127:0] Prdata_m;
    logic [3:0]   Pready_m;
    logic [3:0]   Pslverr_m;

    int n_checks = 0;
    int n_errors = 0;

    apb_bridge_gen dut (
        .PCLK      (PCLK),
        .Prst      (Prst),
        .Hen       (Hen),
        .Hwrite    (Hwrite),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hready    (Hready),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .Psel      (Psel),
        .Pen       (Pen),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata_m  (Prdata_m),
        .Pready_m  (Pready_m),
        .Pslverr_m (Pslverr_m)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        int          waits;
        logic        err;
        logic [31:0] rd;
        bit          hold;
        int          exp_lat;
        logic        exp_resp;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_psel;
        int          exp_pen;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: the transfer outcome straight from the bridge's rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int unsigned sel = v.addr >> 8;
        if (sel < 4) begin
            r.exp_lat   = 3 + v.waits;
            r.exp_resp  = v.err;
            r.exp_rdata = (!v.wr && !v.err) ? v.rd : 32'h0;
            r.exp_psel  = 4'(1 << sel);
            r.exp_pen   = v.waits + 1;
        end else begin
            r.exp_lat   = 1;
            r.exp_resp  = 1'b1;
            r.exp_rdata = 32'h0;
            r.exp_psel  = 4'h0;
            r.exp_pen   = 0;
        end
        return r;
    endfunction

    // Launch one transfer (called #1 after a rising edge), act as the APB
    // slaves, then check the master-side response and the APB activity seen.
    task automatic run_vec(input vec_t v, input string tag);
        bit          hit;
        int          tgt;
        int          lat;
        int          pen_cyc;
        logic [3:0]  psel_or;
        logic [3:0]  first_psel;
        logic        first_pen;
        bit          p_ok;
        logic        got_resp;
        logic [31:0] got_rdata;

        hit = (v.addr[31:8] < 24'd4);
        tgt = hit ? int'(v.addr[9:8]) : 0;
        for (int i = 0; i < 4; i++) begin
            Prdata_m[i*32 +: 32] = (i == tgt) ? v.rd : $urandom;
            Pslverr_m[i]         = (i == tgt) ? v.err : ~v.err;
            Pready_m[i]          = (i == tgt) ? 1'b0 : 1'b1;
        end
        Hen    = 1'b1;
        Hwrite = v.wr;
        Haddr  = v.addr;
        Hwdata = v.wd;

        lat = -1; pen_cyc = 0; psel_or = '0; p_ok = 1'b1;
        first_psel = '0; first_pen = 1'b0; got_resp = 1'b0; got_rdata = '0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge PCLK); #1;
            if (c == 1) begin
                first_psel = Psel;
                first_pen  = Pen;
            end
            psel_or |= Psel;
            if (Psel != 0 && (Paddr !== v.addr || Pwdata !== v.wd || Pwrite !== v.wr))
                p_ok = 1'b0;
            if (Pen) pen_cyc++;
            Pready_m[tgt] = (pen_cyc > v.waits);
            if (Hready) begin
                lat       = c;
                got_resp  = Hresp;
                got_rdata = Hrdata;
                break;
            end
            // Request inputs must be ignored once the transfer has launched.
            Haddr  = $urandom;
            Hwdata = $urandom;
            Hwrite = ~v.wr;
        end
        if (!v.hold) Hen = 1'b0;

        chk({tag, ".latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, ".hresp"}, 64'(got_resp), 64'(v.exp_resp));
        chk({tag, ".hrdata"}, 64'(got_rdata), 64'(v.exp_rdata));
        chk({tag, ".setup_phase"}, 64'({first_psel, first_pen}), 64'({v.exp_psel, 1'b0}));
        chk({tag, ".psel_seen"}, 64'(psel_or), 64'(v.exp_psel));
        chk({tag, ".pen_cycles"}, 64'(pen_cyc), 64'(v.exp_pen));
        chk({tag, ".apb_payload"}, 64'(p_ok), 64'(1));

        // Cycle after RESP: pulse gone, no relaunch even with Hen held, data held.
        @(posedge PCLK); #1;
        chk({tag, ".post_idle"}, 64'({Hready, Hresp, Psel, Pen}), 64'(0));
        chk({tag, ".hrdata_hold"}, 64'(Hrdata), 64'(v.exp_rdata));
        Hen = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   saw_ready;

        //             addr          wr    wd            wt err   rd            hold  lat resp  rdata         psel     pen
        tbl[0] = '{32'h0000_0204, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'hAAAA_5555, 1'b0, 3, 1'b0, 32'h0,         4'b0100, 1};
        tbl[1] = '{32'h0000_0104, 1'b0, 32'h0000_0000, 3, 1'b0, 32'h1234_5678, 1'b0, 6, 1'b0, 32'h1234_5678, 4'b0010, 4};
        tbl[2] = '{32'h0000_0500, 1'b0, 32'h1111_1111, 0, 1'b0, 32'h5555_5555, 1'b0, 1, 1'b1, 32'h0,         4'b0000, 0};
        tbl[3] = '{32'h0000_0300, 1'b0, 32'h0,         0, 1'b1, 32'hCAFE_F00D, 1'b1, 3, 1'b1, 32'h0,         4'b1000, 1};
        tbl[4] = '{32'h0000_00FC, 1'b0, 32'h0,         1, 1'b0, 32'h0BAD_CAFE, 1'b0, 4, 1'b0, 32'h0BAD_CAFE, 4'b0001, 2};
        tbl[5] = '{32'h0000_03FF, 1'b1, 32'h7777_0000, 2, 1'b1, 32'h9999_9999, 1'b0, 5, 1'b1, 32'h0,         4'b1000, 3};
        tbl[6] = '{32'h0000_0400, 1'b0, 32'h0,         0, 1'b0, 32'h2222_2222, 1'b0, 1, 1'b1, 32'h0,         4'b0000, 0};
        tbl[7] = '{32'hFFFF_FF00, 1'b0, 32'h0,         0, 1'b0, 32'h3333_3333, 1'b1, 1, 1'b1, 32'h0,         4'b0000, 0};
        tbl[8] = '{32'h0001_0100, 1'b1, 32'h4444_4444, 0, 1'b0, 32'h0,         1'b0, 1, 1'b1, 32'h0,         4'b0000, 0};
        tbl[9] = '{32'h0000_01F0, 1'b0, 32'h0,         0, 1'b0, 32'hFFFF_FFFF, 1'b0, 3, 1'b0, 32'hFFFF_FFFF, 4'b0010, 1};

        // Reset: outputs cleared and held even with a request pending.
        Prst = 1'b0; Hen = 1'b1; Hwrite = 1'b1; Haddr = 32'h204; Hwdata = 32'h5A5A_5A5A;
        Prdata_m = '1; Pready_m = '1; Pslverr_m = '0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_outputs", 64'({Hready, Hresp, Psel, Pen, Pwrite}), 64'(0));
        chk("reset_buses", 64'({Hrdata, Paddr}) | 64'(Pwdata), 64'(0));
        Hen = 1'b0;
        @(negedge PCLK) Prst = 1'b1;
        @(posedge PCLK); #1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            v.addr  = {24'($urandom_range(0, 5)), 8'($urandom)};
            if ($urandom_range(0, 7) == 0) v.addr[31:12] = 20'($urandom);
            v.wr    = 1'($urandom);
            v.wd    = $urandom;
            v.rd    = $urandom;
            v.waits = $urandom_range(0, 4);
            v.err   = ($urandom_range(0, 3) == 0);
            v.hold  = 1'($urandom);
            run_vec(model(v), $sformatf("rnd%0d", i));
        end

`ifdef APB_BRIDGE_TIMEOUT_EN
        v = '{32'h0000_0208, 1'b0, 32'h0, 100000, 1'b0, 32'h6666_6666, 1'b0, 18, 1'b1, 32'h0, 4'b0100, 16};
        run_vec(v, "timeout");
`endif

        // Stall a read in ACCESS, then reset asynchronously in mid-cycle.
        Pready_m = '0; Pslverr_m = '0;
        Hen = 1'b1; Hwrite = 1'b0; Haddr = 32'h0000_0104; Hwdata = 32'h0;
        saw_ready = 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
        repeat (5) begin
            @(posedge PCLK); #1;
            if (Hready) saw_ready = 1'b1;
        end
`else
        repeat (100) begin
            @(posedge PCLK); #1;
            if (Hready) saw_ready = 1'b1;
        end
`endif
        chk("stall.no_hready", 64'(saw_ready), 64'(0));
        chk("stall.in_access", 64'({Psel, Pen, Paddr}), 64'({4'b0010, 1'b1, 32'h0000_0104}));
        #3;
        Prst = 1'b0;
        #1;
        chk("async_reset.outputs", 64'({Hready, Hresp, Psel, Pen, Pwrite}), 64'(0));
        chk("async_reset.buses", 64'({Hrdata, Paddr}) | 64'(Pwdata), 64'(0));
        Hen = 1'b0;
        saw_ready = 1'b0;
        repeat (3) begin
            @(posedge PCLK); #1;
            if (Hready) saw_ready = 1'b1;
        end
        chk("async_reset.no_hready", 64'(saw_ready), 64'(0));
        @(negedge PCLK) Prst = 1'b1;
        @(posedge PCLK); #1;
        run_vec(tbl[0], "after_reset");
        run_vec(tbl[1], "after_reset_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
